// File: rtl/tcdm_bank_pkg.sv
// -----------------------------------------------------------------------------
// tcdm_bank_pkg
// Shared types and helpers for the TCDM bank responder.
// -----------------------------------------------------------------------------
package tcdm_bank_pkg;

   // Bank operating state: INIT fills the array, READY serves requests.
   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } bank_state_e;

   // Word-address width for a bank of num_words words (never below 1 bit).
   function automatic int unsigned addr_width(input int unsigned num_words);
      return (num_words > 1) ? $clog2(num_words) : 1;
   endfunction

endpackage : tcdm_bank_pkg

// File: rtl/tcdm_bank_resp_pipe.sv
// -----------------------------------------------------------------------------
// tcdm_bank_resp_pipe
// Delay line of {vld, data} response slots. It carries the response from the
// memory read register through the remaining RespLat-1 stages. It shifts every
// cycle and is cleared synchronously, so in-flight responses vanish on reset.
// -----------------------------------------------------------------------------
module tcdm_bank_resp_pipe #(
   parameter int unsigned Depth     = 1,
   parameter int unsigned DataWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_vld_i,
   input  logic [DataWidth-1:0] in_data_i,
   output logic                 out_vld_o,
   output logic [DataWidth-1:0] out_data_o
);

   logic [Depth-1:0]                vld_q, vld_d;
   logic [Depth-1:0][DataWidth-1:0] data_q, data_d;

   // Next state of the delay line: new entry at slot 0, everything else moves up.
   always_comb begin
      // NOTE: every combinational output gets a default first so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      vld_d     = '0;
      data_d    = '0;
      vld_d[0]  = in_vld_i;
      data_d[0] = in_data_i;
      for (int unsigned i = 1; i < Depth; i++) begin
         vld_d[i]  = vld_q[i-1];
         data_d[i] = data_q[i-1];
      end
   end

   // Slot registers with synchronous clear.
   always_ff @(posedge clk_i) begin
      // NOTE: state is updated with non-blocking assignments so that every
      // flop samples the pre-edge values; blocking here would collapse stages.
      if (rst_i) begin
         vld_q  <= '0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign out_vld_o  = vld_q[Depth-1];
   assign out_data_o = data_q[Depth-1];

endmodule : tcdm_bank_resp_pipe

// File: rtl/tcdm_bank_resp.sv
// -----------------------------------------------------------------------------
// tcdm_bank_resp
// Target-side endpoint of the TCDM request/grant protocol. It sits on one bank
// port of the interconnect. After reset it writes InitValue to every word
// (INIT, NumWords cycles) and does not grant during that time. It then grants
// requests combinationally. It performs one read or write per cycle on the
// word array and returns a response exactly RespLat cycles after acceptance.
//
// Optional build macro: TCDM_BANK_STALL_EN adds a stall_i input that
// suppresses grants while high. Responses already accepted still complete
// on schedule.
// -----------------------------------------------------------------------------
module tcdm_bank_resp
   import tcdm_bank_pkg::*;
#(
   parameter int unsigned          NumWords    = 256,
   parameter int unsigned          DataWidth   = 32,
   parameter int unsigned          RespLat     = 1,
   parameter bit                   WriteRespOn = 1'b1,
   parameter logic [DataWidth-1:0] InitValue   = '0
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        req_i,
   output logic                        gnt_o,
   input  logic [$clog2(NumWords)-1:0] add_i,
   input  logic                        wen_i,
   input  logic [DataWidth-1:0]        wdata_i,
   output logic [DataWidth-1:0]        rdata_o,
   output logic                        vld_o,
`ifdef TCDM_BANK_STALL_EN
   input  logic                        stall_i,
`endif
   output logic                        init_done_o
);

   localparam int unsigned          AddrWidth = addr_width(NumWords);
   localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(NumWords - 1);

   // Control state
   bank_state_e          state_q, state_d;
   logic [AddrWidth-1:0] cnt_q, cnt_d;

   // Word array and its single write port
   logic [DataWidth-1:0] mem_q [NumWords];
   logic                 mem_we;
   logic [AddrWidth-1:0] mem_waddr;
   logic [DataWidth-1:0] mem_wdata;

   // Response stage 1 (memory read register)
   logic                 s1_vld_q, s1_vld_d;
   logic [DataWidth-1:0] s1_data_q, s1_data_d;

   logic                 stall;
   logic                 gnt;

`ifdef TCDM_BANK_STALL_EN
   assign stall = stall_i;
`else
   assign stall = 1'b0;
`endif

   // Sequencing, grant and write-port selection.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gnt       = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = cnt_q;
      mem_wdata = InitValue;
      unique case (state_q)
         INIT: begin
            // Fill one word per cycle. The requester keeps req_i held and
            // simply sees no grant until the fill completes.
            mem_we = 1'b1;
            cnt_d  = cnt_q + AddrWidth'(1);
            if (cnt_q == LastAddr) begin
               state_d = READY;
            end
         end
         READY: begin
            // A grant in a reset cycle would be a lie because the operation is
            // discarded. rst_i therefore masks it as well.
            gnt = req_i & ~stall & ~rst_i;
            if (gnt && wen_i) begin
               mem_we    = 1'b1;
               mem_waddr = add_i;
               mem_wdata = wdata_i;
            end
         end
         default: state_d = INIT;
      endcase
   end

   // Stage-1 response: reads capture the addressed word. Writes carry zero
   // data and only produce a valid when write responses are enabled.
   always_comb begin
      s1_vld_d  = gnt & (~wen_i | WriteRespOn);
      s1_data_d = '0;
      if (gnt && !wen_i) begin
         s1_data_d = mem_q[add_i];
      end
   end

   // Control and stage-1 registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= INIT;
         cnt_q     <= '0;
         s1_vld_q  <= 1'b0;
         s1_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         s1_vld_q  <= s1_vld_d;
         s1_data_q <= s1_data_d;
      end
   end

   // Word array write port.
   always_ff @(posedge clk_i) begin
      // NOTE: the array has no reset branch. The INIT sequence defines its
      // contents, and a reset on every word would block RAM inference.
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Remaining RespLat-1 stages, or a direct output when RespLat is 1.
   generate
      if (RespLat > 1) begin : g_pipe
         tcdm_bank_resp_pipe #(
            .Depth     (RespLat - 1),
            .DataWidth (DataWidth)
         ) i_pipe (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .in_vld_i   (s1_vld_q),
            .in_data_i  (s1_data_q),
            .out_vld_o  (vld_o),
            .out_data_o (rdata_o)
         );
      end else begin : g_no_pipe
         assign vld_o   = s1_vld_q;
         assign rdata_o = s1_data_q;
      end
   endgenerate

   assign gnt_o       = gnt;
   assign init_done_o = (state_q == READY);

endmodule : tcdm_bank_resp

// File: tb/tb_tcdm_bank_resp.sv
// -----------------------------------------------------------------------------
// tb_tcdm_bank_resp
// Three banks (NumWords=16) share one stimulus stream:
//   dut_a: RespLat=1, WriteRespOn=1
//   dut_b: RespLat=3, WriteRespOn=0
//   dut_c: RespLat=2, WriteRespOn=1
// Inputs change 1 time unit after a rising edge. Outputs are sampled on the
// following falling edge. Response vectors are packed as {vld_a, vld_b, vld_c}.
// -----------------------------------------------------------------------------
module tb_tcdm_bank_resp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        wen = 1'b0;
   logic [3:0]  add = '0;
   logic [31:0] wdata = '0;
`ifdef TCDM_BANK_STALL_EN
   logic        stall = 1'b0;
`endif

   logic        gnt_a, gnt_b, gnt_c;
   logic        vld_a, vld_b, vld_c;
   logic        done_a, done_b, done_c;
   logic [31:0] rdata_a, rdata_b, rdata_c;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   tcdm_bank_resp #(
      .NumWords(16), .DataWidth(32), .RespLat(1), .WriteRespOn(1'b1), .InitValue(32'h0)
   ) dut_a (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_a), .add_i(add), .wen_i(wen),
      .wdata_i(wdata), .rdata_o(rdata_a), .vld_o(vld_a),
`ifdef TCDM_BANK_STALL_EN
      .stall_i(stall),
`endif
      .init_done_o(done_a)
   );

   tcdm_bank_resp #(
      .NumWords(16), .DataWidth(32), .RespLat(3), .WriteRespOn(1'b0), .InitValue(32'h0)
   ) dut_b (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_b), .add_i(add), .wen_i(wen),
      .wdata_i(wdata), .rdata_o(rdata_b), .vld_o(vld_b),
`ifdef TCDM_BANK_STALL_EN
      .stall_i(stall),
`endif
      .init_done_o(done_b)
   );

   tcdm_bank_resp #(
      .NumWords(16), .DataWidth(32), .RespLat(2), .WriteRespOn(1'b1), .InitValue(32'h0)
   ) dut_c (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_c), .add_i(add), .wen_i(wen),
      .wdata_i(wdata), .rdata_o(rdata_c), .vld_o(vld_c),
`ifdef TCDM_BANK_STALL_EN
      .stall_i(stall),
`endif
      .init_done_o(done_c)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // One cycle: drive inputs just after the edge, then wait for the falling edge.
   task automatic cyc(input logic rs, input logic rq, input logic we,
                      input logic [3:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      rst   = rs;
      req   = rq;
      wen   = we;
      add   = a;
      wdata = d;
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
   endtask

   task automatic expect_rsp(input string tag, input logic [2:0] v,
                             input logic [31:0] da, input logic [31:0] db, input logic [31:0] dc);
      check({tag, ".vld"},     32'({vld_a, vld_b, vld_c}), 32'(v));
      check({tag, ".rdata_a"}, rdata_a, da);
      check({tag, ".rdata_b"}, rdata_b, db);
      check({tag, ".rdata_c"}, rdata_c, dc);
   endtask

   task automatic expect_gnt(input string tag, input logic [2:0] g);
      check(tag, 32'({gnt_a, gnt_b, gnt_c}), 32'(g));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held with req high: everything quiet.
      cyc(1'b1, 1'b1, 1'b0, 4'd5, 32'h0);
      cyc(1'b1, 1'b1, 1'b0, 4'd5, 32'h0);
      expect_gnt("rst.gnt", 3'b000);
      check("rst.done", 32'({done_a, done_b, done_c}), 32'h0);
      expect_rsp("rst", 3'b000, 32'h0, 32'h0, 32'h0);

      // Test 1: INIT lasts cycles 0..15 with no grant despite req held.
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 4'd5, 32'h0);
         expect_gnt($sformatf("t1.init_gnt[%0d]", i), 3'b000);
         check($sformatf("t1.init_done[%0d]", i), 32'({done_a, done_b, done_c}), 32'h0);
      end
      cyc(1'b0, 1'b1, 1'b0, 4'd5, 32'h0);          // cycle 16: read addr 5 accepted
      expect_gnt("t1.ready_gnt", 3'b111);
      check("t1.ready_done", 32'({done_a, done_b, done_c}), 32'h7);
      expect_rsp("t1.c16", 3'b000, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t1.c17", 3'b100, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t1.c18", 3'b001, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t1.c19", 3'b010, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t1.c20", 3'b000, 32'h0, 32'h0, 32'h0);

      // Test 2: write then read of addr 3.
      cyc(1'b0, 1'b1, 1'b1, 4'd3, 32'hDEADBEEF);
      expect_rsp("t2.t0", 3'b000, 32'h0, 32'h0, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 4'd3, 32'h0);
      expect_rsp("t2.t1", 3'b100, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t2.t2", 3'b101, 32'hDEADBEEF, 32'h0, 32'h0);
      idle(); expect_rsp("t2.t3", 3'b001, 32'h0, 32'h0, 32'hDEADBEEF);
      idle(); expect_rsp("t2.t4", 3'b010, 32'h0, 32'hDEADBEEF, 32'h0);
      idle(); expect_rsp("t2.t5", 3'b000, 32'h0, 32'h0, 32'h0);

      // Test 3: preload 0/1/2, back-to-back reads, ordered responses.
      cyc(1'b0, 1'b1, 1'b1, 4'd0, 32'h11);
      expect_rsp("t3.s0", 3'b000, 32'h0, 32'h0, 32'h0);
      cyc(1'b0, 1'b1, 1'b1, 4'd1, 32'h22);
      expect_rsp("t3.s1", 3'b100, 32'h0, 32'h0, 32'h0);
      cyc(1'b0, 1'b1, 1'b1, 4'd2, 32'h33);
      expect_rsp("t3.s2", 3'b101, 32'h0, 32'h0, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 4'd0, 32'h0);
      expect_rsp("t3.s3", 3'b101, 32'h0, 32'h0, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 4'd1, 32'h0);
      expect_rsp("t3.s4", 3'b101, 32'h11, 32'h0, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 4'd2, 32'h0);
      expect_rsp("t3.s5", 3'b101, 32'h22, 32'h0, 32'h11);
      idle(); expect_rsp("t3.s6", 3'b111, 32'h33, 32'h11, 32'h22);
      idle(); expect_rsp("t3.s7", 3'b011, 32'h0, 32'h22, 32'h33);
      idle(); expect_rsp("t3.s8", 3'b010, 32'h0, 32'h33, 32'h0);
      idle(); expect_rsp("t3.s9", 3'b000, 32'h0, 32'h0, 32'h0);

      // Test 4: lone write; dut_b (no write responses) stays silent.
      cyc(1'b0, 1'b1, 1'b1, 4'd7, 32'hA5A5A5A5);
      expect_rsp("t4.u0", 3'b000, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t4.u1", 3'b100, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t4.u2", 3'b001, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t4.u3", 3'b000, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t4.u4", 3'b000, 32'h0, 32'h0, 32'h0);

      // Test 5: read in flight, then reset; in-flight responses are discarded.
      cyc(1'b0, 1'b1, 1'b0, 4'd3, 32'h0);
      expect_rsp("t5.v0", 3'b000, 32'h0, 32'h0, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
      expect_rsp("t5.v1", 3'b100, 32'hDEADBEEF, 32'h0, 32'h0);
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 4'd3, 32'h0);
         expect_gnt($sformatf("t5.reinit_gnt[%0d]", i), 3'b000);
         check($sformatf("t5.reinit_vld[%0d]", i), 32'({vld_a, vld_b, vld_c}), 32'h0);
      end
      cyc(1'b0, 1'b1, 1'b0, 4'd3, 32'h0);
      expect_gnt("t5.ready_gnt", 3'b111);
      expect_rsp("t5.accept", 3'b000, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t5.r1", 3'b100, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t5.r2", 3'b001, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t5.r3", 3'b010, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t5.r4", 3'b000, 32'h0, 32'h0, 32'h0);

`ifdef TCDM_BANK_STALL_EN
      // Test 6: stall suppresses grants; the first unstalled cycle is accepted.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 4'd0, 32'h0);
         expect_gnt($sformatf("t6.stall_gnt[%0d]", i), 3'b000);
         expect_rsp($sformatf("t6.stall[%0d]", i), 3'b000, 32'h0, 32'h0, 32'h0);
      end
      @(posedge clk);
      #1;
      stall = 1'b0;
      @(negedge clk);
      expect_gnt("t6.release_gnt", 3'b111);
      expect_rsp("t6.release", 3'b000, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t6.r1", 3'b100, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t6.r2", 3'b001, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t6.r3", 3'b010, 32'h0, 32'h0, 32'h0);
      idle(); expect_rsp("t6.r4", 3'b000, 32'h0, 32'h0, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_tcdm_bank_resp
